fx_sum_sequencer: RTL and testbench
===================================

FX_SUM_SEQUENCER -- requirements
Module: fx_sum_sequencer

Interface
REQ-001 Parameter MEM_LAT, default 2: fixed read latency in clk_en cycles from mem_rd to valid mem_rdata; legal range 1..7.
REQ-002 Parameter N_W, default 16: width of the element-count input.
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port clk_en  input  1  global enable; when low, all registers hold.
REQ-006 Port go  input  1  single-cycle job request.
REQ-007 Port base_addr  input  32  byte address of element 0, word aligned; sampled on accepted go.
REQ-008 Port n  input  N_W  element count; sampled on accepted go.
REQ-009 Port busy  output  1  high from accepted go until result_valid cycle inclusive.
REQ-010 Port result_valid  output  1  one-cycle pulse marking result valid.
REQ-011 Port result  output  32  IEEE-754 single accumulated sum; holds until next result_valid.
REQ-012 Port mem_rd  output  1  one-cycle read strobe.
REQ-013 Port mem_addr  output  32  read byte address.
REQ-014 Port mem_rdata  input  32  read data, valid MEM_LAT cycles after mem_rd.
REQ-015 Port eval_x  output  32  element value to evaluator.
REQ-016 Port eval_sum  output  32  running sum to evaluator.
REQ-017 Port eval_start  output  1  one-cycle evaluator start.
REQ-018 Port eval_done  input  1  evaluator completion pulse.
REQ-019 Port eval_new_sum  input  32  eval_sum + f(eval_x), valid while eval_done high.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT_MEM, EVAL_START, EVAL_WAIT, FINISH.
REQ-021 IDLE: go with n>0 SHALL clear sum_reg to 0x00000000, idx to 0, latch base_addr and n, go to FETCH.
REQ-022 IDLE: go with n==0 SHALL go to FINISH directly with sum_reg 0x00000000.
REQ-023 FETCH: mem_rd high exactly one cycle, mem_addr = base + 4*idx (32-bit wrap); next WAIT_MEM.
REQ-024 WAIT_MEM: latency counter counts MEM_LAT cycles; on final count capture mem_rdata into x_reg; next EVAL_START.
REQ-025 EVAL_START: eval_start high exactly one cycle; next EVAL_WAIT.
REQ-026 eval_x = x_reg and eval_sum = sum_reg SHALL be stable from EVAL_START until cycle after eval_done.
REQ-027 EVAL_WAIT: on eval_done capture eval_new_sum into sum_reg, increment idx; if idx+1==n go FINISH, else FETCH.
REQ-028 eval_done outside EVAL_WAIT SHALL be ignored.
REQ-029 FINISH: result <= sum_reg, result_valid high one cycle, next IDLE; busy low from following cycle.
REQ-030 go while busy SHALL be ignored (no queueing).
REQ-031 n = 2^N_W-1 SHALL complete without idx overflow (idx is N_W bits).
REQ-032 Per-element cycles = 1 + MEM_LAT + 1 + evaluator latency (start-to-done) + 0; job with zero elements yields result_valid 1 cycle after go.
REQ-033 clk_en low SHALL freeze FSM, counters and outputs; strobes resume where stopped.

Reset
REQ-034 Reset SHALL force IDLE; busy, result_valid, mem_rd, eval_start = 0; result, mem_addr, eval_x, eval_sum, sum_reg, idx = 0.
REQ-035 Reset mid-job SHALL abandon the job; no result_valid; a pending eval_done after reset ignored.
REQ-036 Reset SHALL take priority over clk_en.

Structure
REQ-037 State enum and FP constant FP_ZERO SHALL live in shared package fx_pkg.
REQ-038 Single sub-module SHALL NOT be required; latency counter inline.

Verification
REQ-039 Stub evaluator (new_sum = sum + x, done 5 cycles after start), n=3, memory {1.0,2.0,3.0} -> result 0x40C00000, one result_valid pulse.
REQ-040 Real evaluator, n=1, memory {0x43000000 (128.0)} -> result 0x46808000 (16448.0).
REQ-041 go with n=0 -> result_valid next cycle, result 0x00000000, no mem_rd, no eval_start.
REQ-042 Second go during busy -> ignored, first result unchanged, busy profile unchanged.
REQ-043 Reset asserted during EVAL_WAIT, eval_done arrives afterwards -> stays IDLE, no result_valid, all outputs 0.
REQ-044 clk_en toggled randomly 50% during n=3 stub job -> same result 0x40C00000, each strobe counted once.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared definitions for the floating-point sum sequencer: FSM encoding,
// FP constants and the element address helper.
package fx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        EVAL_START,
        EVAL_WAIT,
        FINISH
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Byte address of a 32-bit element; wraps naturally at 2^32.
    function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/fx_sum_sequencer.sv
// Walks an array of IEEE-754 singles in memory, hands each element to an
// external evaluator together with the running sum, and reports the final sum.
module fx_sum_sequencer
    import fx_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int N_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_en,
    input  logic           go,
    input  logic [31:0]    base_addr,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           result_valid,
    output logic [31:0]    result,
    output logic           mem_rd,
    output logic [31:0]    mem_addr,
    input  logic [31:0]    mem_rdata,
    output logic [31:0]    eval_x,
    output logic [31:0]    eval_sum,
    output logic           eval_start,
    input  logic           eval_done,
    input  logic [31:0]    eval_new_sum
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t         state;
    logic [31:0]    base_reg;
    logic [31:0]    x_reg;
    logic [31:0]    sum_reg;
    logic [N_W-1:0] n_reg;
    logic [N_W-1:0] idx;
    logic [2:0]     lat_cnt;
    logic           last_elem;

    // Comparing against n-1 keeps idx at N_W bits even for the largest n.
    assign last_elem = (idx == n_reg - N_W'(1));

    assign eval_x   = x_reg;
    assign eval_sum = sum_reg;

    // NOTE: every register here is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= FP_ZERO;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            eval_start   <= 1'b0;
            base_reg     <= '0;
            x_reg        <= '0;
            sum_reg      <= FP_ZERO;
            n_reg        <= '0;
            idx          <= '0;
            lat_cnt      <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (go) begin
                        busy     <= 1'b1;
                        base_reg <= base_addr;
                        n_reg    <= n;
                        idx      <= '0;
                        sum_reg  <= FP_ZERO;
                        if (n != '0) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= base_addr;
                            state    <= FETCH;
                        end else begin
                            result       <= FP_ZERO;
                            result_valid <= 1'b1;
                            state        <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    mem_rd  <= 1'b0;
                    lat_cnt <= '0;
                    state   <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (lat_cnt == LAT_LAST) begin
                        x_reg      <= mem_rdata;
                        eval_start <= 1'b1;
                        state      <= EVAL_START;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                EVAL_START: begin
                    eval_start <= 1'b0;
                    state      <= EVAL_WAIT;
                end
                EVAL_WAIT: begin
                    if (eval_done) begin
                        sum_reg <= eval_new_sum;
                        idx     <= idx + N_W'(1);
                        if (last_elem) begin
                            result       <= eval_new_sum;
                            result_valid <= 1'b1;
                            state        <= FINISH;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= elem_addr(base_reg, 32'(idx + N_W'(1)));
                            state    <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_sum_sequencer.sv
// Self-checking bench for fx_sum_sequencer: memory and evaluator models,
// directed vector table, reset/overlap corner cases and randomized jobs.
module tb_fx_sum_sequencer;

    localparam int MEM_LAT = 3;
    localparam int N_W     = 4;

    logic           clk = 1'b0;
    logic           reset, clk_en, go;
    logic [31:0]    base_addr;
    logic [N_W-1:0] n;
    logic           busy, result_valid, mem_rd, eval_start, eval_done;
    logic [31:0]    result, mem_addr, mem_rdata, eval_x, eval_sum, eval_new_sum;

    always #5 clk = ~clk;

    fx_sum_sequencer #(.MEM_LAT(MEM_LAT), .N_W(N_W)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .go(go),
        .base_addr(base_addr), .n(n), .busy(busy),
        .result_valid(result_valid), .result(result),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .eval_x(eval_x), .eval_sum(eval_sum), .eval_start(eval_start),
        .eval_done(eval_done), .eval_new_sum(eval_new_sum)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single <-> real conversion for the exactly representable values used here.
    function automatic real sp2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic real f_elem(input real x, input bit real_mode);
        return real_mode ? (x * x + x / 2.0) : x;
    endfunction

    // Memory: fixed MEM_LAT pipeline advancing on enabled edges.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (clk_en) begin
            rd_pipe[0] <= mem_rd ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
            for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Evaluator: stub (sum + x) or real (sum + x*x + x/2), done ev_lat cycles after start.
    bit          ev_real = 1'b0;
    int          ev_lat  = 5;
    int          ev_cnt  = 0;
    logic [31:0] ev_x    = '0;
    logic [31:0] ev_s    = '0;
    always @(posedge clk) begin
        if (clk_en) begin
            if (eval_start) begin
                ev_cnt <= ev_lat;
                ev_x   <= eval_x;
                ev_s   <= eval_sum;
            end else if (ev_cnt != 0) begin
                ev_cnt <= ev_cnt - 1;
            end
        end
    end
    assign eval_done = (ev_cnt == 1);
    always_comb eval_new_sum = r2sp(sp2r(ev_s) + f_elem(sp2r(ev_x), ev_real));

    // Monitor: counts effective (enabled) cycles and each strobe once.
    int          en_cyc = 0;
    int          rv_cnt, st_cnt, busy_cnt, rv_at;
    logic [31:0] rv_val;
    logic [31:0] addr_q[$];
    logic [31:0] x_q[$];
    always @(negedge clk) begin
        if (!reset && clk_en) begin
            if (mem_rd) addr_q.push_back(mem_addr);
            if (eval_start) begin
                st_cnt++;
                x_q.push_back(eval_x);
            end
            if (result_valid) begin
                rv_cnt++;
                rv_at  = en_cyc;
                rv_val = result;
            end
            if (busy) busy_cnt++;
            en_cyc++;
        end
    end

    task automatic clear_monitor();
        rv_cnt = 0; st_cnt = 0; busy_cnt = 0; rv_at = -1; rv_val = '0;
        addr_q.delete();
        x_q.delete();
    endtask

    task automatic run_job(input string tag, input bit real_ev, input bit rand_en,
                           input logic [31:0] base, input int cnt, input int extra_go,
                           input logic [31:0] exp_result);
        int go_at, exp_lat, k;
        ev_real = real_ev;
        ev_lat  = real_ev ? 3 : 5;
        exp_lat = (cnt == 0) ? 1 : cnt * (2 + MEM_LAT + ev_lat) + 1;
        clear_monitor();
        @(posedge clk) #1;
        clk_en = 1'b1; go = 1'b1; base_addr = base; n = N_W'(cnt);
        go_at = en_cyc;
        @(posedge clk) #1;
        go = 1'b0; base_addr = 32'h0BAD_0000; n = '1;
        k = 0;
        while (rv_cnt == 0 && k < 20000) begin
            clk_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (extra_go > 0 && k == extra_go) begin
                go = 1'b1; clk_en = 1'b1; base_addr = 32'h0000_0400; n = N_W'(1);
            end
            @(posedge clk) #1;
            go = 1'b0;
            k++;
        end
        clk_en = 1'b1;
        repeat (4) @(posedge clk) #1;
        check({tag, " result"}, rv_val, exp_result);
        check({tag, " result_valid pulses"}, 32'(rv_cnt), 32'd1);
        check({tag, " latency"}, 32'(rv_at - go_at), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " eval_start count"}, 32'(st_cnt), 32'(cnt));
        check({tag, " mem_rd count"}, 32'(addr_q.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < addr_q.size(); i++)
            check($sformatf("%s addr[%0d]", tag, i), addr_q[i], base + 32'(4 * i));
        for (int i = 0; i < cnt && i < x_q.size(); i++)
            check($sformatf("%s eval_x[%0d]", tag, i), x_q[i],
                  mem[6'(((base >> 2) + 32'(i)) & 32'd63)]);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " result held"}, result, exp_result);
    endtask

    typedef struct {
        bit          real_ev;
        bit          rand_en;
        logic [31:0] base;
        int          cnt;
        logic [31:0] elem [3];
        int          extra_go;
        logic [31:0] exp_result;
    } vec_t;

    function automatic vec_t mk(input bit re, input bit rn, input logic [31:0] b, input int c,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input int xg, input logic [31:0] ex);
        vec_t v;
        v.real_ev = re; v.rand_en = rn; v.base = b; v.cnt = c;
        v.elem[0] = e0; v.elem[1] = e1; v.elem[2] = e2;
        v.extra_go = xg; v.exp_result = ex;
        return v;
    endfunction

    task automatic reset_mid_job();
        int k;
        mem[0] = 32'h3F80_0000;
        ev_real = 1'b0; ev_lat = 5;
        clear_monitor();
        @(posedge clk) #1;
        clk_en = 1'b1; go = 1'b1; base_addr = 32'h0; n = N_W'(1);
        @(posedge clk) #1;
        go = 1'b0;
        k = 0;
        while (st_cnt == 0 && k < 200) begin
            @(posedge clk) #1;
            k++;
        end
        repeat (2) @(posedge clk) #1;
        check("rst busy during eval wait", 32'(busy), 32'd1);
        clk_en = 1'b0; reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst eval_x", eval_x, 32'd0);
        check("rst result", result, 32'd0);
        clk_en = 1'b1;
        repeat (10) @(posedge clk) #1;
        check("rst no result_valid", 32'(rv_cnt), 32'd0);
        check("rst idle busy", 32'(busy), 32'd0);
        check("rst idle mem_rd count", 32'(addr_q.size()), 32'd1);
        check("rst idle mem_addr", mem_addr, 32'd0);
        check("rst idle eval_sum", eval_sum, 32'd0);
        check("rst idle eval_start", 32'(eval_start), 32'd0);
        check("rst idle result", result, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = mk(0, 0, 32'h0000_0100, 3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 32'h40C0_0000);
        vecs[1] = mk(1, 0, 32'h0000_0200, 1, 32'h4300_0000, 32'h0,         32'h0,         0, 32'h4680_8000);
        vecs[2] = mk(0, 0, 32'h0000_0300, 0, 32'h0,         32'h0,         32'h0,         0, 32'h0000_0000);
        vecs[3] = mk(0, 1, 32'h0000_0100, 3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 32'h40C0_0000);
        vecs[4] = mk(0, 0, 32'h0000_0100, 3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6, 32'h40C0_0000);
        vecs[5] = mk(1, 0, 32'hFFFF_FFF8, 3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 32'h4188_0000);

        for (int i = 0; i < 64; i++) mem[i] = 32'h7F80_0001;
        reset = 1'b1; clk_en = 1'b0; go = 1'b0; base_addr = '0; n = '0;
        repeat (3) @(posedge clk) #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset eval_start", 32'(eval_start), 32'd0);
        check("reset result", result, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset eval_x", eval_x, 32'd0);
        check("reset eval_sum", eval_sum, 32'd0);
        reset = 1'b0; clk_en = 1'b1;
        repeat (2) @(posedge clk) #1;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].cnt; i++)
                mem[6'(((vecs[v].base >> 2) + 32'(i)) & 32'd63)] = vecs[v].elem[i];
            run_job($sformatf("vec%0d", v), vecs[v].real_ev, vecs[v].rand_en, vecs[v].base,
                    vecs[v].cnt, vecs[v].extra_go, vecs[v].exp_result);
        end

        reset_mid_job();

        for (int j = 0; j < 6; j++) begin
            int          cnt, val;
            bit          rm, re;
            logic [31:0] base;
            real         acc;
            cnt  = (j == 0) ? 15 : int'($urandom_range(0, 15));
            rm   = 1'($urandom_range(0, 1));
            re   = 1'($urandom_range(0, 1));
            base = $urandom & 32'hFFFF_FFFC;
            acc  = 0.0;
            for (int i = 0; i < cnt; i++) begin
                val = int'($urandom_range(0, 255));
                mem[6'(((base >> 2) + 32'(i)) & 32'd63)] = r2sp(real'(val));
                acc = acc + f_elem(real'(val), rm);
            end
            run_job($sformatf("rand%0d", j), rm, re, base, cnt, 0, r2sp(acc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
